// File: rtl/rv_core_pkg.sv
// Shared state encodings, ALU operations and RV OP/OP-IMM field constants
// for the multi-cycle core and its ALU.
package rv_core_pkg;

  typedef logic [2:0] state_e;
  localparam state_e S_IDLE      = 3'd0;
  localparam state_e S_FETCH     = 3'd1;
  localparam state_e S_DECODE    = 3'd2;
  localparam state_e S_EXECUTE   = 3'd3;
  localparam state_e S_WRITEBACK = 3'd4;
  localparam state_e S_HALT      = 3'd5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // alt selects the funct7=0100000 flavour (sub / sra)
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU over XLEN bits; shifts use the low log2(XLEN)
// bits of b and MUL returns the low XLEN bits of the product.
module rv_alu
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SH = $clog2(XLEN);

  logic [SH-1:0] shamt;
  assign shamt = b[SH-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_MUL:  result = a * b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV integer core: FETCH/DECODE/EXECUTE/WRITEBACK sequencing with a
// request/valid instruction fetch, inline register file and sticky illegal halt.
module rv_multicycle_core
  import rv_core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            retire_o,
  output logic [XLEN-1:0] retire_pc_o,
  output logic            wb_en_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            illegal_o
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned SH = $clog2(XLEN);
  localparam logic [11:0] SRA_BIT = 12'h400 >> SH;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0]     ir_q, ir_d;
  alu_op_e         op_q, op_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [11:0]     imm12, shamt_hi;
  logic [XLEN-1:0] imm_sext, rs1_val, rs2_val, alu_res;
  logic            rs1_ok, rs2_ok, rd_writable;
  logic            dec_legal, dec_use_imm;
  alu_op_e         dec_op;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm12    = ir_q[31:20];
  assign imm_sext = {{(XLEN-12){imm12[11]}}, imm12};
  assign shamt_hi = imm12 >> SH;

  assign rs1_ok      = ({27'd0, rs1} < NUM_REGS);
  assign rs2_ok      = ({27'd0, rs2} < NUM_REGS);
  assign rd_writable = (rd != 5'd0) && ({27'd0, rd} < NUM_REGS);
  assign rs1_val     = regs_q[rs1[AW-1:0]];
  assign rs2_val     = regs_q[rs2[AW-1:0]];

  // Legality and ALU op selection; anything not matched stays illegal.
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_op      = ALU_ADD;
    if (opcode == OPC_OP && rs1_ok && rs2_ok) begin
      case (funct7)
        F7_BASE: begin
          dec_legal = 1'b1;
          dec_op    = f3_to_op(funct3, 1'b0);
        end
        F7_ALT: begin
          dec_legal = (funct3 == F3_ADD) || (funct3 == F3_SR);
          dec_op    = f3_to_op(funct3, 1'b1);
        end
        F7_MULDIV: begin
          dec_legal = (funct3 == F3_ADD);
          dec_op    = ALU_MUL;
        end
        default: dec_legal = 1'b0;
      endcase
    end else if (opcode == OPC_OP_IMM && rs1_ok) begin
      dec_use_imm = 1'b1;
      case (funct3)
        F3_SLL: begin
          dec_legal = (shamt_hi == 12'd0);
          dec_op    = ALU_SLL;
        end
        F3_SR: begin
          dec_legal = ((shamt_hi & ~SRA_BIT) == 12'd0);
          dec_op    = imm12[10] ? ALU_SRA : ALU_SRL;
        end
        default: begin
          dec_legal = 1'b1;
          dec_op    = f3_to_op(funct3, 1'b0);
        end
      endcase
    end
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    regs_d    = regs_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          a_d     = rs1_val;
          b_d     = dec_use_imm ? imm_sext : rs2_val;
          op_d    = dec_op;
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXECUTE: begin
        c_d     = alu_res;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (rd_writable) regs_d[rd[AW-1:0]] = c_q;
        pc_d    = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
        state_d = start_i ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      op_q      <= ALU_ADD;
      illegal_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  // Retire-port outputs read as zero outside WRITEBACK.
  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign retire_o    = (state_q == S_WRITEBACK);
  assign retire_pc_o = retire_o ? pc_q : '0;
  assign wb_en_o     = retire_o && rd_writable;
  assign wb_addr_o   = retire_o ? rd : 5'd0;
  assign wb_data_o   = retire_o ? c_q : '0;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core: acts as the instruction memory, keeps a
// queue of expected retirements and checks each retirement as it appears.
module tb_rv_multicycle_core;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_valid_i = 1'b0;
  logic [31:0]     imem_rdata_i = 32'h0;
  logic            retire_o;
  logic [XLEN-1:0] retire_pc_o;
  logic            wb_en_o;
  logic [4:0]      wb_addr_o;
  logic [XLEN-1:0] wb_data_o;
  logic            illegal_o;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  rv_multicycle_core #(.XLEN(XLEN), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_valid_i (imem_valid_i),
    .imem_rdata_i (imem_rdata_i),
    .retire_o     (retire_o),
    .retire_pc_o  (retire_pc_o),
    .wb_en_o      (wb_en_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered on a negedge with the core in FETCH; leaves one negedge after retire.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] exp_pc,
                               input logic exp_en, input logic [4:0] exp_addr,
                               input logic [31:0] exp_data, input int waits,
                               input bit stray, input bit drop_start);
    exp_t e;
    exp_t got_e;
    bit   got = 1'b0;
    int   lat = 0;
    e = '{pc: exp_pc, en: exp_en, addr: exp_addr, data: exp_data};
    sb_q.push_back(e);
    for (int n = 0; n < 40 && !got; n++) begin
      if (retire_o === 1'b1) begin
        got = 1'b1;
        lat = n + 1;
      end else begin
        if (n <= waits) begin
          checkOutput("fetch_req", 64'(imem_req_o), 64'd1);
          checkOutput("fetch_addr", 64'(imem_addr_o), 64'(exp_pc));
        end
        imem_valid_i = (n == waits) || (stray && n == waits + 2);
        imem_rdata_i = (n == waits) ? instr : 32'h0;
        if (drop_start && n == waits + 1) start_i = 1'b0;
        @(negedge clk_i);
      end
    end
    imem_valid_i = 1'b0;
    if (!got) begin
      checkOutput("retire_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end else begin
      checkOutput("latency", 64'(lat), 64'(waits + 4));
      checkOutput("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        got_e = sb_q.pop_front();
        checkOutput("retire_pc", 64'(retire_pc_o), 64'(got_e.pc));
        checkOutput("wb_en", 64'(wb_en_o), 64'(got_e.en));
        checkOutput("wb_addr", 64'(wb_addr_o), 64'(got_e.addr));
        if (got_e.en) checkOutput("wb_data", 64'(wb_data_o), 64'(got_e.data));
      end
    end
    @(negedge clk_i);
    checkOutput("retire_pulse", 64'(retire_o), 64'd0);
  endtask

  // Entered in FETCH; feeds an illegal word, checks the halt, then resets.
  task automatic runIllegal(input logic [31:0] word, input logic [31:0] exp_pc);
    checkOutput("ill_fetch_addr", 64'(imem_addr_o), 64'(exp_pc));
    imem_valid_i = 1'b1;
    imem_rdata_i = word;
    @(negedge clk_i);
    imem_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ill_flag", 64'(illegal_o), 64'd1);
    checkOutput("ill_no_retire", 64'(retire_o), 64'd0);
    checkOutput("ill_no_req", 64'(imem_req_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      imem_valid_i = k[0];
      start_i      = ~k[0];
      imem_rdata_i = 32'h00500093;
      @(negedge clk_i);
      checkOutput("halt_req", 64'(imem_req_o), 64'd0);
      checkOutput("halt_retire", 64'(retire_o), 64'd0);
      checkOutput("halt_sticky", 64'(illegal_o), 64'd1);
      checkOutput("halt_pc", 64'(imem_addr_o), 64'(exp_pc));
    end
    imem_valid_i = 1'b0;
    start_i      = 1'b0;
    rst_i        = 1'b0;
    #1;
    checkOutput("rst_ill_clear", 64'(illegal_o), 64'd0);
    checkOutput("rst_pc", 64'(imem_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_idle", 64'(imem_req_o), 64'd0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk_i);
    checkOutput("rst_req", 64'(imem_req_o), 64'd0);
    checkOutput("rst_addr", 64'(imem_addr_o), 64'd0);
    checkOutput("rst_retire", 64'(retire_o), 64'd0);
    checkOutput("rst_retire_pc", 64'(retire_pc_o), 64'd0);
    checkOutput("rst_wb_en", 64'(wb_en_o), 64'd0);
    checkOutput("rst_wb_addr", 64'(wb_addr_o), 64'd0);
    checkOutput("rst_wb_data", 64'(wb_data_o), 64'd0);
    checkOutput("rst_illegal", 64'(illegal_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle_no_req", 64'(imem_req_o), 64'd0);
    start_i = 1'b1;
    @(negedge clk_i);

    applyStimulus(32'h00500093, 32'd0,  1'b1, 5'd1, 32'h00000005, 0, 1'b0, 1'b0);
    applyStimulus(32'hFFD00113, 32'd4,  1'b1, 5'd2, 32'hFFFFFFFD, 0, 1'b0, 1'b0);
    applyStimulus(32'h002081B3, 32'd8,  1'b1, 5'd3, 32'h00000002, 0, 1'b0, 1'b0);
    applyStimulus(32'h40208233, 32'd12, 1'b1, 5'd4, 32'h00000008, 0, 1'b0, 1'b0);
    applyStimulus(32'h022082B3, 32'd16, 1'b1, 5'd5, 32'hFFFFFFF1, 0, 1'b0, 1'b0);
    applyStimulus(32'h40115313, 32'd20, 1'b1, 5'd6, 32'hFFFFFFFE, 0, 1'b0, 1'b0);
    applyStimulus(32'h00700013, 32'd24, 1'b0, 5'd0, 32'h00000000, 0, 1'b0, 1'b0);
    applyStimulus(32'h001003B3, 32'd28, 1'b1, 5'd7, 32'h00000005, 0, 1'b0, 1'b0);
    applyStimulus(32'h0020E433, 32'd32, 1'b1, 5'd8, 32'hFFFFFFFD, 3, 1'b1, 1'b0);
    applyStimulus(32'h0020B4B3, 32'd36, 1'b1, 5'd9, 32'h00000001, 0, 1'b0, 1'b0);
    applyStimulus(32'h0020A533, 32'd40, 1'b1, 5'd10, 32'h00000000, 0, 1'b0, 1'b0);
    applyStimulus(32'hFFF0B593, 32'd44, 1'b1, 5'd11, 32'h00000001, 0, 1'b0, 1'b0);
    applyStimulus(32'h00409613, 32'd48, 1'b1, 5'd12, 32'h00000050, 0, 1'b0, 1'b0);
    applyStimulus(32'h001156B3, 32'd52, 1'b1, 5'd13, 32'h07FFFFFF, 0, 1'b0, 1'b0);
    applyStimulus(32'h00117733, 32'd56, 1'b1, 5'd14, 32'h00000005, 0, 1'b0, 1'b0);
    applyStimulus(32'hFFF0C793, 32'd60, 1'b1, 5'd15, 32'hFFFFFFFA, 0, 1'b0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      imem_valid_i = 1'b1;
      checkOutput("stopped_req", 64'(imem_req_o), 64'd0);
      checkOutput("stopped_pc", 64'(imem_addr_o), 64'd64);
      @(negedge clk_i);
    end
    imem_valid_i = 1'b0;

    start_i = 1'b1;
    @(negedge clk_i);
    checkOutput("resume_addr", 64'(imem_addr_o), 64'd64);
    imem_valid_i = 1'b1;
    imem_rdata_i = 32'h06300093;
    @(negedge clk_i);
    imem_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("midrst_pc", 64'(imem_addr_o), 64'd0);
    checkOutput("midrst_retire", 64'(retire_o), 64'd0);
    checkOutput("midrst_wb_en", 64'(wb_en_o), 64'd0);
    @(negedge clk_i);
    checkOutput("midrst_hold_retire", 64'(retire_o), 64'd0);
    rst_i   = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    applyStimulus(32'h00308893, 32'd0, 1'b1, 5'd17, 32'h00000003, 0, 1'b0, 1'b0);

    runIllegal(32'h00000000, 32'd4);
    start_i = 1'b1;
    @(negedge clk_i);
    runIllegal(32'h40209233, 32'd0);

    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Parametrised multi-cycle successor to the single-cycle CPU top. One FSM sequences each instruction through fetch, decode, execute and writeback. Instruction fetch uses a variable-latency request/valid handshake instead of a combinational ROM. Adds XLEN/register-count parameters, the full RV OP/OP-IMM integer set plus MUL, illegal-instruction halt, and a retire/writeback observation port for the bench.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- NUM_REGS, 32, architectural registers; power of two, 2..32; x0 hardwired to zero.
- RESET_PC, 0, PC value after reset.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable; sampled in IDLE and at end of WRITEBACK.
- imem_req_o  out  1  fetch request; high throughout FETCH.
- imem_addr_o  out  XLEN  fetch address, equal to PC.
- imem_valid_i  in  1  instruction valid; honoured only in FETCH.
- imem_rdata_i  in  32  instruction word.
- retire_o  out  1  one-cycle pulse in WRITEBACK.
- retire_pc_o  out  XLEN  PC of the retiring instruction.
- wb_en_o  out  1  register write this cycle; low when rd is x0.
- wb_addr_o  out  5  rd.
- wb_data_o  out  XLEN  write data.
- illegal_o  out  1  sticky; set on illegal decode; cleared only by reset.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: start_i=1 moves to FETCH.
- FETCH: drives imem_req_o=1 and imem_addr_o=PC, both held stable until imem_valid_i=1. On valid, captures IR and moves to DECODE.
- DECODE: reads rs1 and rs2 into A and B, and sign-extends imm[11:0] to XLEN.
  - Illegal instruction: sets illegal_o and moves to HALT. Register file and PC are unchanged.
- EXECUTE: computes ALU result into C.
- WRITEBACK:
  - Writes C to rd, unless rd is x0 or rd ≥ NUM_REGS; in either case wb_en_o=0, with no error.
  - PC ← PC+4, wrapping modulo 2^XLEN.
  - Pulses retire_o.
  - Next state is FETCH if start_i=1, else IDLE.
- HALT: absorbing state; only reset exits.
- Legal OP (0110011), funct7 0000000 or 0100000: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
- Legal OP, funct7 0000001, funct3 000: mul, low XLEN bits of the product.
- Legal OP-IMM (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
- Everything else is illegal, including:
  - any other opcode;
  - other funct7 values;
  - rs1 or rs2 ≥ NUM_REGS.
- Shift amounts:
  - taken from the low log2(XLEN) bits of B or imm;
  - OP-IMM shifts with imm[11:log2 XLEN] outside {0, 0100000<<…} are illegal.
- slt compares signed; sltu compares unsigned with an unsigned view of the sign-extended imm. Result is zero-extended 0/1.
- For XLEN=64, 32-bit ops behave as full-width ops; no W variants.

## Timing
- Reset values:
  - state=IDLE, PC=RESET_PC;
  - all registers 0, IR=0;
  - every output 0, except imem_addr_o=RESET_PC and retire_pc_o=0.
- Instruction latency: 4 cycles when imem_valid_i arrives in the first FETCH cycle. Each extra wait cycle adds one.
- Back-to-back: WRITEBACK is followed directly by FETCH, with no bubble.
- start_i dropped mid-instruction: the current instruction completes; the core stops in IDLE after WRITEBACK.
- imem_valid_i outside FETCH is ignored.
- Reset asserted mid-instruction: immediate return to the reset state; no partial writeback.

## Structure
- Package rv_core_pkg holds:
  - state_e;
  - alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL);
  - opcode and funct constants.
- Sub-module rv_alu: combinational ALU over XLEN, with ports a, b, op, result.
- The register file stays inline.

## Test plan
- addi x1,x0,5 (0x00500093), then addi x2,x0,-3 (0xFFD00113):
  - wb_data_o=5, then 0xFFFFFFFD;
  - retire_pc_o=0, then 4;
  - exactly 4 cycles per instruction with zero-wait imem.
- Continue with add x3 (0x002081B3), sub x4 (0x40208233), mul x5 (0x022082B3), srai x6,x2,1 (0x40115313):
  - results 2, 8, 0xFFFFFFF1, 0xFFFFFFFE.
- addi x0,x0,7 (0x00700013): retire_o=1, wb_en_o=0; a later read of x0 returns 0.
- imem_valid_i delayed 3 cycles with imem_addr_o checked stable: latency becomes 7 cycles.
  - A stray valid during EXECUTE has no effect.
- Word 0x00000000:
  - illegal_o=1, state HALT, no retire;
  - further imem_valid_i and start_i toggles do nothing;
  - rst_i low clears everything.
- start_i dropped during DECODE: the instruction retires, then imem_req_o stays 0.
  - Reset pulsed during EXECUTE: rd is not written and PC=RESET_PC.
